// File: rtl/vic_wb_buffer_pkg.sv
// vic_wb_buffer_pkg: shared cache/bus definitions used by the victim write-back buffer.
package vic_wb_buffer_pkg;
  localparam int NUM_SET_BITS = 4;
  localparam int NUM_TAG_BITS = 64 - NUM_SET_BITS - 3;
  localparam int KEY_W = NUM_TAG_BITS + NUM_SET_BITS;
  typedef enum logic [1:0] {BUS_NONE, BUS_LOAD, BUS_STORE} BUS_COMMAND;
  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [NUM_TAG_BITS-1:0] tag;
    logic [63:0]             data;
  } CACHE_LINE_T;
  typedef struct packed {
    CACHE_LINE_T             line;
    logic [NUM_SET_BITS-1:0] idx;
  } VIC_CACHE_T;
  typedef struct packed {
    logic                    valid;
    logic [NUM_TAG_BITS-1:0] tag;
    logic [NUM_SET_BITS-1:0] idx;
    logic [63:0]             data;
  } WB_ENTRY_T;
endpackage

// File: rtl/vic_wb_buffer_cam.sv
// vic_wb_buffer_cam: parallel key match of NQ queries against all enabled entries.
module vic_wb_buffer_cam #(
  parameter int ENTRIES = 8,
  parameter int KEY_W   = 61,
  parameter int NQ      = 1
) (
  input  logic [ENTRIES-1:0][KEY_W-1:0] keys,
  input  logic [ENTRIES-1:0]            en,
  input  logic [NQ-1:0][KEY_W-1:0]      q,
  output logic [NQ-1:0][ENTRIES-1:0]    hit
);
  for (genvar n = 0; n < NQ; n++) begin : g_q
    for (genvar e = 0; e < ENTRIES; e++) begin : g_e
      assign hit[n][e] = en[e] && (keys[e] == q[n]);
    end
  end
endmodule

// File: rtl/vic_wb_buffer.sv
// vic_wb_buffer: coalescing FIFO write-back buffer for dirty victim-cache evictions.
// Define VIC_WB_FWD_EN to build the rd_hit/rd_data forwarding lookup.
module vic_wb_buffer
  import vic_wb_buffer_pkg::*;
#(
  parameter int WR_PORTS = 3,
  parameter int RD_PORTS = 2,
  parameter int DEPTH    = 8
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  VIC_CACHE_T [WR_PORTS-1:0]               evicted_vic,
  input  logic [WR_PORTS-1:0]                     evicted_valid,
  input  logic [RD_PORTS-1:0]                     rd_en,
  input  logic [RD_PORTS-1:0][NUM_SET_BITS-1:0]   rd_idx,
  input  logic [RD_PORTS-1:0][NUM_TAG_BITS-1:0]   rd_tag,
  input  logic                                    mem_gnt,
  input  logic [3:0]                              mem2proc_response,
  output BUS_COMMAND                              proc2mem_command,
  output logic [63:0]                             proc2mem_addr,
  output logic [63:0]                             proc2mem_data,
  output logic                                    wb_req,
  output logic                                    wb_full,
  output logic [RD_PORTS-1:0]                     rd_hit,
  output logic [RD_PORTS-1:0][63:0]               rd_data
);
  localparam int AW = $clog2(DEPTH);

  WB_ENTRY_T                     wb_q [DEPTH];
  WB_ENTRY_T                     wb_d [DEPTH];
  logic [AW-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [AW:0]                   count_q, count_d, nalloc, free, sel;
  logic [DEPTH-1:0][KEY_W-1:0]   keys;
  logic [DEPTH-1:0]              vld, coal_en;
  logic [WR_PORTS-1:0][KEY_W-1:0] wr_key;
  logic [WR_PORTS-1:0][DEPTH-1:0] wr_hit;
  logic [WR_PORTS-1:0]           accept, take;
  logic                          issue, pop;

  // {found, slot} of the youngest matching entry, scanning from head towards tail
  function automatic logic [AW:0] youngest(input logic [DEPTH-1:0] hit, input logic [AW-1:0] head);
    logic [AW:0] r;
    r = '0;
    for (int k = 0; k < DEPTH; k++)
      if (hit[head + AW'(k)]) r = {1'b1, head + AW'(k)};
    return r;
  endfunction

  assign issue   = (count_q != '0) && mem_gnt;
  assign pop     = issue && (mem2proc_response != 4'd0);
  assign coal_en = vld & ~(issue ? (DEPTH'(1) << head_q) : '0);

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      keys[e] = {wb_q[e].tag, wb_q[e].idx};
      vld[e]  = wb_q[e].valid;
    end
    for (int i = 0; i < WR_PORTS; i++) begin
      wr_key[i] = {evicted_vic[i].line.tag, evicted_vic[i].idx};
      accept[i] = evicted_valid[i] && evicted_vic[i].line.valid && evicted_vic[i].line.dirty;
    end
  end

  vic_wb_buffer_cam #(.ENTRIES(DEPTH), .KEY_W(KEY_W), .NQ(WR_PORTS)) u_wr_cam (
    .keys(keys),
    .en  (coal_en),
    .q   (wr_key),
    .hit (wr_hit)
  );

  always_comb begin
    wb_d   = wb_q;
    nalloc = '0;
    sel    = '0;
    free   = (AW+1)'(DEPTH) - count_q + (AW+1)'(pop);
    take   = accept;
    for (int i = 0; i < WR_PORTS; i++)
      for (int k = i + 1; k < WR_PORTS; k++)
        if (accept[k] && (wr_key[k] == wr_key[i])) take[i] = 1'b0;
    // clear the popped slot first so a full buffer can refill it this cycle
    if (pop) wb_d[head_q].valid = 1'b0;
    for (int i = 0; i < WR_PORTS; i++) begin
      sel = youngest(wr_hit[i], head_q);
      if (take[i] && sel[AW]) wb_d[sel[AW-1:0]].data = evicted_vic[i].line.data;
      else if (take[i] && (nalloc < free)) begin
        wb_d[tail_q + nalloc[AW-1:0]] = '{1'b1, evicted_vic[i].line.tag, evicted_vic[i].idx, evicted_vic[i].line.data};
        nalloc = nalloc + (AW+1)'(1);
      end
    end
    head_d  = head_q + AW'(pop);
    tail_d  = tail_q + nalloc[AW-1:0];
    count_d = count_q - (AW+1)'(pop) + nalloc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < DEPTH; e++) wb_q[e] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      wb_q    <= wb_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign proc2mem_command = issue ? BUS_STORE : BUS_NONE;
  assign proc2mem_addr    = issue ? {wb_q[head_q].tag, wb_q[head_q].idx, 3'b000} : '0;
  assign proc2mem_data    = issue ? wb_q[head_q].data : '0;
  assign wb_req           = count_q != '0;
  assign wb_full          = ((AW+1)'(DEPTH) - count_q) < (AW+1)'(WR_PORTS);

`ifdef VIC_WB_FWD_EN
  logic [RD_PORTS-1:0][KEY_W-1:0] rd_key;
  logic [RD_PORTS-1:0][DEPTH-1:0] rd_match;
  logic [AW:0]                    rd_sel;

  always_comb
    for (int j = 0; j < RD_PORTS; j++) rd_key[j] = {rd_tag[j], rd_idx[j]};

  vic_wb_buffer_cam #(.ENTRIES(DEPTH), .KEY_W(KEY_W), .NQ(RD_PORTS)) u_rd_cam (
    .keys(keys),
    .en  (vld),
    .q   (rd_key),
    .hit (rd_match)
  );

  always_comb begin
    rd_sel  = '0;
    rd_hit  = '0;
    rd_data = '0;
    for (int j = 0; j < RD_PORTS; j++) begin
      rd_sel     = youngest(rd_match[j], head_q);
      rd_hit[j]  = rd_en[j] && rd_sel[AW];
      rd_data[j] = rd_hit[j] ? wb_q[rd_sel[AW-1:0]].data : '0;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_en, rd_idx, rd_tag};
  assign rd_hit    = '0;
  assign rd_data   = '0;
`endif
endmodule
